// File: rtl/sdb_pkg.sv
// Shared types and constants for the SD boot sequencer.
// Contents: FSM state enum, SD command frame struct, opcodes, core flag bit
// indices and the error codes reported on sdb_errcode_o.
package sdb_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_INIT,
      ST_CMD_SETUP,
      ST_CMD_ISSUE,
      ST_DATA,
      ST_BLK_DONE,
      ST_RETRY,
      ST_DONE,
      ST_ERROR
   } state_e;

   localparam logic [7:0] CMD17   = 8'h51;
   localparam logic [7:0] CMD_CRC = 8'hFF;
   localparam logic [7:0] OP_READ = 8'h11;
   localparam logic [7:0] OP_IDLE = 8'h00;

   localparam int unsigned WORDS_PER_BLK = 128;
   localparam int unsigned CNT_W         = 8;
   localparam int unsigned TO_W          = 20;

   localparam int unsigned FLAG_VALID    = 0;
   localparam int unsigned FLAG_BLK_DONE = 1;
   localparam int unsigned FLAG_ERR      = 2;

   localparam logic [1:0] ERR_NONE    = 2'b00;
   localparam logic [1:0] ERR_INIT_TO = 2'b01;
   localparam logic [1:0] ERR_DATA_TO = 2'b10;
   localparam logic [1:0] ERR_RETRY   = 2'b11;

   // 48-bit SPI command frame handed to the core
   typedef struct packed {
      logic [7:0]  opcode;
      logic [31:0] arg;
      logic [7:0]  crc;
   } sd_cmd_t;

   function automatic sd_cmd_t cmd17_frame(input logic [31:0] lba);
      sd_cmd_t f;
      f.opcode = CMD17;
      f.arg    = lba;
      f.crc    = CMD_CRC;
      return f;
   endfunction

endpackage

// File: rtl/sdb_timeout_ctr.sv
// Inactivity counter shared by the init wait and the data wait.
// Ports: clk/rst_n (async active-low), clear (restart count), enable (count
// this cycle), expired_c (count has reached LIMIT; decoded from the register).
module sdb_timeout_ctr #(
   parameter int unsigned         CNT_W = 20,
   parameter logic [CNT_W-1:0]    LIMIT = '1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic expired_c
);

   logic [CNT_W-1:0] cnt_q;

   // Saturating up-counter; clear has priority over counting
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (clear) begin
         cnt_q <= '0;
      end else if (enable && (cnt_q != LIMIT)) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   assign expired_c = (cnt_q == LIMIT);

endmodule

// File: rtl/sd_boot_sequencer.sv
// Boot-time loader driving the SPI microSDHC core: initialises the card,
// reads NUM_BLOCKS consecutive blocks from START_LBA with CMD17 and writes the
// returned words to boot memory, with per-block retries and inactivity timeouts.
// Ports:
//   sdb_clk_i, sdb_rst_i        clock, async active-low reset
//   sdb_start_i                 start request (sampled in IDLE only)
//   spi_init_o / spi_initdone_i card init request / acknowledge
//   spi_enableoper_o            one-cycle command strobe
//   spi_statusreg_o, spi_cmd_o  opcode and command frame to the core
//   spi_data_i, spi_flagreg_i   read word and {err, blk_done, valid} pulses
//   mem_we_o/addr_o/data_o      boot memory write port
//   sdb_busy_o/done_o/err_o     status; done/err are sticky
//   sdb_errcode_o               01 init timeout, 10 data timeout, 11 retries exhausted
module sd_boot_sequencer
   import sdb_pkg::*;
#(
   parameter logic [31:0] START_LBA  = 32'd0,
   parameter int unsigned NUM_BLOCKS = 8,
   parameter int unsigned MEM_AW     = 12,
   parameter logic [19:0] TIMEOUT    = 20'd100000,
   parameter int unsigned MAX_RETRY  = 3
) (
   input  logic              sdb_clk_i,
   input  logic              sdb_rst_i,
   input  logic              sdb_start_i,
   output logic              spi_init_o,
   input  logic              spi_initdone_i,
   output logic              spi_enableoper_o,
   output logic [7:0]        spi_statusreg_o,
   output logic [47:0]       spi_cmd_o,
   input  logic [31:0]       spi_data_i,
   input  logic [2:0]        spi_flagreg_i,
   output logic              mem_we_o,
   output logic [MEM_AW-1:0] mem_addr_o,
   output logic [31:0]       mem_data_o,
   output logic              sdb_busy_o,
   output logic              sdb_done_o,
   output logic              sdb_err_o,
   output logic [1:0]        sdb_errcode_o
);

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   blk_idx_q, blk_idx_d;
   logic [CNT_W-1:0]   word_cnt_q, word_cnt_d;
   logic [CNT_W-1:0]   retry_cnt_q, retry_cnt_d;
   logic               last_to_q, last_to_d;
   sd_cmd_t            cmd_q, cmd_d;

   logic               mem_we_d;
   logic [MEM_AW-1:0]  mem_addr_d;
   logic [31:0]        mem_data_d;
   logic               done_d, err_d;
   logic [1:0]         errcode_d;
   logic               busy_d, init_d, enoper_d;
   logic [7:0]         status_d;

   logic               to_clear, to_enable, to_expired;
   logic               blk_full;

   assign spi_cmd_o = cmd_q;
   assign blk_full  = (32'(word_cnt_q) == WORDS_PER_BLK);

   // Inactivity restarts on every state change and on any core flag
   assign to_clear  = (state_d != state_q) || (|spi_flagreg_i);
   assign to_enable = (state_q == ST_INIT) || (state_q == ST_DATA);

   sdb_timeout_ctr #(
      .CNT_W (TO_W),
      .LIMIT (TIMEOUT)
   ) u_timeout (
      .clk       (sdb_clk_i),
      .rst_n     (sdb_rst_i),
      .clear     (to_clear),
      .enable    (to_enable),
      .expired_c (to_expired)
   );

   // Next-state and next-output logic; outputs are registered from these
   always_comb begin
      state_d     = state_q;
      blk_idx_d   = blk_idx_q;
      word_cnt_d  = word_cnt_q;
      retry_cnt_d = retry_cnt_q;
      last_to_d   = last_to_q;
      cmd_d       = cmd_q;
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr_o;
      mem_data_d  = mem_data_o;
      done_d      = sdb_done_o;
      err_d       = sdb_err_o;
      errcode_d   = sdb_errcode_o;

      case (state_q)
         ST_IDLE: begin
            if (sdb_start_i) state_d = ST_INIT;
         end

         ST_INIT: begin
            if (spi_initdone_i) begin
               state_d = ST_CMD_SETUP;
            end else if (to_expired) begin
               state_d   = ST_ERROR;
               err_d     = 1'b1;
               errcode_d = ERR_INIT_TO;
            end
         end

         ST_CMD_SETUP: begin
            cmd_d      = cmd17_frame(START_LBA + 32'(blk_idx_q));
            word_cnt_d = '0;
            state_d    = ST_CMD_ISSUE;
         end

         ST_CMD_ISSUE: begin
            state_d = ST_DATA;
         end

         // Error beats block-complete beats word-valid; no write on a failing cycle
         ST_DATA: begin
            if (spi_flagreg_i[FLAG_ERR]) begin
               state_d   = ST_RETRY;
               last_to_d = 1'b0;
            end else if (spi_flagreg_i[FLAG_BLK_DONE]) begin
               state_d   = blk_full ? ST_BLK_DONE : ST_RETRY;
               last_to_d = 1'b0;
            end else if (spi_flagreg_i[FLAG_VALID]) begin
               if (blk_full) begin
                  state_d   = ST_RETRY;
                  last_to_d = 1'b0;
               end else begin
                  mem_we_d   = 1'b1;
                  mem_data_d = spi_data_i;
                  mem_addr_d = MEM_AW'(32'(blk_idx_q) * WORDS_PER_BLK + 32'(word_cnt_q));
                  word_cnt_d = word_cnt_q + CNT_W'(1);
               end
            end else if (to_expired) begin
               state_d   = ST_RETRY;
               last_to_d = 1'b1;
            end
         end

         ST_BLK_DONE: begin
            blk_idx_d   = blk_idx_q + CNT_W'(1);
            retry_cnt_d = '0;
            if (32'(blk_idx_q) + 32'd1 == NUM_BLOCKS) begin
               state_d = ST_DONE;
               done_d  = 1'b1;
            end else begin
               state_d = ST_CMD_SETUP;
            end
         end

         // Re-issue the same block; its write addresses restart at the block base
         ST_RETRY: begin
            if (32'(retry_cnt_q) < MAX_RETRY) begin
               retry_cnt_d = retry_cnt_q + CNT_W'(1);
               state_d     = ST_CMD_SETUP;
            end else begin
               state_d   = ST_ERROR;
               err_d     = 1'b1;
               errcode_d = last_to_q ? ERR_DATA_TO : ERR_RETRY;
            end
         end

         ST_DONE, ST_ERROR: begin
            state_d = state_q;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      busy_d   = !((state_d == ST_IDLE) || (state_d == ST_DONE) || (state_d == ST_ERROR));
      init_d   = (state_d != ST_IDLE);
      enoper_d = (state_d == ST_CMD_ISSUE);
      status_d = (busy_d && (state_d != ST_INIT)) ? OP_READ : OP_IDLE;
   end

   // State, counters and registered outputs
   always_ff @(posedge sdb_clk_i or negedge sdb_rst_i) begin
      if (!sdb_rst_i) begin
         state_q          <= ST_IDLE;
         blk_idx_q        <= '0;
         word_cnt_q       <= '0;
         retry_cnt_q      <= '0;
         last_to_q        <= 1'b0;
         cmd_q            <= '0;
         spi_init_o       <= 1'b0;
         spi_enableoper_o <= 1'b0;
         spi_statusreg_o  <= OP_IDLE;
         mem_we_o         <= 1'b0;
         mem_addr_o       <= '0;
         mem_data_o       <= '0;
         sdb_busy_o       <= 1'b0;
         sdb_done_o       <= 1'b0;
         sdb_err_o        <= 1'b0;
         sdb_errcode_o    <= ERR_NONE;
      end else begin
         state_q          <= state_d;
         blk_idx_q        <= blk_idx_d;
         word_cnt_q       <= word_cnt_d;
         retry_cnt_q      <= retry_cnt_d;
         last_to_q        <= last_to_d;
         cmd_q            <= cmd_d;
         spi_init_o       <= init_d;
         spi_enableoper_o <= enoper_d;
         spi_statusreg_o  <= status_d;
         mem_we_o         <= mem_we_d;
         mem_addr_o       <= mem_addr_d;
         mem_data_o       <= mem_data_d;
         sdb_busy_o       <= busy_d;
         sdb_done_o       <= done_d;
         sdb_err_o        <= err_d;
         sdb_errcode_o    <= errcode_d;
      end
   end

endmodule

// File: tb/tb_sd_boot_sequencer.sv
// Self-checking bench for sd_boot_sequencer: a behavioural SPI core answers
// each CMD17 according to a per-attempt plan (clean, error, short, overflow,
// silent, partial) with random data and random gaps; expected commands,
// memory image, write count and final status are derived from the plan.
module tb_sd_boot_sequencer;

   localparam int unsigned NB   = 2;
   localparam logic [31:0] SLBA = 32'h100;
   localparam int unsigned AW   = 12;
   localparam logic [19:0] TO   = 20'd1000;
   localparam int unsigned MR   = 3;

   localparam int M_CLEAN   = 0;
   localparam int M_ERR     = 1;
   localparam int M_SHORT   = 2;
   localparam int M_OVER    = 3;
   localparam int M_TIMEOUT = 4;
   localparam int M_PARTIAL = 5;

   logic          clk;
   logic          rst_n;
   logic          sdb_start_i;
   logic          spi_init_o;
   logic          spi_initdone_i;
   logic          spi_enableoper_o;
   logic [7:0]    spi_statusreg_o;
   logic [47:0]   spi_cmd_o;
   logic [31:0]   spi_data_i;
   logic [2:0]    spi_flagreg_i;
   logic          mem_we_o;
   logic [AW-1:0] mem_addr_o;
   logic [31:0]   mem_data_o;
   logic          sdb_busy_o;
   logic          sdb_done_o;
   logic          sdb_err_o;
   logic [1:0]    sdb_errcode_o;

   sd_boot_sequencer #(
      .START_LBA  (SLBA),
      .NUM_BLOCKS (NB),
      .MEM_AW     (AW),
      .TIMEOUT    (TO),
      .MAX_RETRY  (MR)
   ) dut (
      .sdb_clk_i        (clk),
      .sdb_rst_i        (rst_n),
      .sdb_start_i      (sdb_start_i),
      .spi_init_o       (spi_init_o),
      .spi_initdone_i   (spi_initdone_i),
      .spi_enableoper_o (spi_enableoper_o),
      .spi_statusreg_o  (spi_statusreg_o),
      .spi_cmd_o        (spi_cmd_o),
      .spi_data_i       (spi_data_i),
      .spi_flagreg_i    (spi_flagreg_i),
      .mem_we_o         (mem_we_o),
      .mem_addr_o       (mem_addr_o),
      .mem_data_o       (mem_data_o),
      .sdb_busy_o       (sdb_busy_o),
      .sdb_done_o       (sdb_done_o),
      .sdb_err_o        (sdb_err_o),
      .sdb_errcode_o    (sdb_errcode_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   int          exp_wr = 0;
   logic [31:0] exp_mem [0:4095];
   logic [47:0] exp_cmd [$];
   int          p_blk [$];
   int          p_mode [$];
   int          p_arg [$];

   // Observed side, owned by the monitor
   logic        log_clr = 1'b0;
   logic [31:0] dut_mem [0:4095];
   int          wr_count = 0;
   int          en_count = 0;
   logic [47:0] cmd_log [$];

   always @(negedge clk) begin
      if (log_clr) begin
         wr_count <= 0;
         en_count <= 0;
         for (int i = 0; i < 4096; i++) dut_mem[i] <= 32'h0;
      end else begin
         if (mem_we_o) begin
            dut_mem[mem_addr_o] <= mem_data_o;
            wr_count <= wr_count + 1;
         end
         if (spi_enableoper_o) begin
            en_count <= en_count + 1;
            cmd_log.push_back(spi_cmd_o);
         end
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_all();
      cmd_log.delete();
      exp_cmd.delete();
      p_blk.delete();
      p_mode.delete();
      p_arg.delete();
      exp_wr = 0;
      for (int i = 0; i < 4096; i++) exp_mem[i] = 32'h0;
      log_clr = 1'b1;
      @(negedge clk);
      @(posedge clk);
      log_clr = 1'b0;
      @(negedge clk);
   endtask

   task automatic reset_dut();
      @(negedge clk);
      rst_n          = 1'b0;
      sdb_start_i    = 1'b0;
      spi_initdone_i = 1'b0;
      spi_flagreg_i  = 3'b000;
      spi_data_i     = 32'h0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      clear_all();
   endtask

   task automatic add(input int blk, input int mode, input int arg);
      p_blk.push_back(blk);
      p_mode.push_back(mode);
      p_arg.push_back(arg);
   endtask

   task automatic start_init(input int delay);
      sdb_start_i = 1'b1;
      @(negedge clk);
      sdb_start_i = 1'b0;
      chk("init_req", 64'(spi_init_o), 64'd1);
      chk("busy_init", 64'(sdb_busy_o), 64'd1);
      repeat (delay) @(negedge clk);
      chk("no_cmd_before_init", 64'(en_count), 64'd0);
      spi_initdone_i = 1'b1;
   endtask

   // One core flag pulse, then the write it should (or should not) cause
   task automatic pulse(input logic [2:0] f, input logic [31:0] d, input logic exp_we,
                        input int exp_addr, input string tag);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      spi_flagreg_i = f;
      spi_data_i    = d;
      @(negedge clk);
      spi_flagreg_i = 3'b000;
      chk({tag, "_we"}, 64'(mem_we_o), 64'(exp_we));
      if (exp_we) begin
         chk({tag, "_addr"}, 64'(mem_addr_o), 64'(exp_addr));
         chk({tag, "_data"}, 64'(mem_data_o), 64'(d));
      end
   endtask

   task automatic serve(input int blk, input int mode, input int arg);
      logic [31:0] w;
      int          n;
      @(negedge clk);
      chk("status_read", 64'(spi_statusreg_o), 64'h11);
      case (mode)
         M_CLEAN, M_OVER: n = 128;
         M_SHORT:         n = 127;
         M_ERR, M_PARTIAL: n = arg;
         default:         n = 0;
      endcase
      for (int i = 0; i < n; i++) begin
         w = (mode == M_CLEAN && arg == 1) ? 32'hA000_0000 + 32'(i) : $urandom;
         pulse(3'b001, w, 1'b1, blk * 128 + i, "word");
         if (mode == M_CLEAN) exp_mem[blk * 128 + i] = w;
      end
      exp_wr += n;
      case (mode)
         M_CLEAN, M_SHORT: pulse(3'b010, 32'h0, 1'b0, 0, "blkdone");
         M_ERR:            pulse(3'b100 | 3'($urandom_range(0, 1)), $urandom, 1'b0, 0, "err");
         M_OVER:           pulse(3'b001, $urandom, 1'b0, 0, "overflow");
         default: ;
      endcase
   endtask

   task automatic wait_enable(output logic ok);
      ok = 1'b0;
      for (int c = 0; c < 2500 && !ok; c++) begin
         if (spi_enableoper_o) ok = 1'b1;
         else @(negedge clk);
      end
      chk("enable_seen", 64'(ok), 64'd1);
   endtask

   task automatic do_load();
      logic ok;
      for (int a = 0; a < p_blk.size(); a++) begin
         exp_cmd.push_back({8'h51, SLBA + 32'(p_blk[a]), 8'hFF});
         wait_enable(ok);
         if (!ok) return;
         serve(p_blk[a], p_mode[a], p_arg[a]);
      end
   endtask

   task automatic wait_term(input int budget);
      logic seen;
      seen = 1'b0;
      for (int c = 0; c < budget && !seen; c++) begin
         if (sdb_done_o || sdb_err_o) seen = 1'b1;
         else @(negedge clk);
      end
      chk("terminal_seen", 64'(seen), 64'd1);
   endtask

   task automatic check_final(input logic exp_done, input logic exp_err,
                              input logic [1:0] exp_code, input logic check_mem);
      int bad;
      int n;
      repeat (20) @(negedge clk);
      chk("done", 64'(sdb_done_o), 64'(exp_done));
      chk("err", 64'(sdb_err_o), 64'(exp_err));
      chk("errcode", 64'(sdb_errcode_o), 64'(exp_code));
      chk("busy_end", 64'(sdb_busy_o), 64'd0);
      chk("status_end", 64'(spi_statusreg_o), 64'h00);
      chk("cmd_count", 64'(cmd_log.size()), 64'(exp_cmd.size()));
      chk("write_count", 64'(wr_count), 64'(exp_wr));
      n = (cmd_log.size() < exp_cmd.size()) ? cmd_log.size() : exp_cmd.size();
      for (int i = 0; i < n; i++) chk("cmd_frame", 64'(cmd_log[i]), 64'(exp_cmd[i]));
      if (check_mem) begin
         bad = 0;
         for (int i = 0; i < int'(NB) * 128; i++) if (dut_mem[i] !== exp_mem[i]) bad++;
         chk("mem_contents", 64'(bad), 64'd0);
      end
   endtask

   initial begin
      int cyc;
      rst_n          = 1'b0;
      sdb_start_i    = 1'b0;
      spi_initdone_i = 1'b0;
      spi_flagreg_i  = 3'b000;
      spi_data_i     = 32'h0;
      repeat (2) @(negedge clk);

      // Reset values
      chk("rst_init", 64'(spi_init_o), 64'd0);
      chk("rst_en", 64'(spi_enableoper_o), 64'd0);
      chk("rst_status", 64'(spi_statusreg_o), 64'h00);
      chk("rst_cmd", 64'(spi_cmd_o), 64'h0);
      chk("rst_we", 64'(mem_we_o), 64'd0);
      chk("rst_busy", 64'(sdb_busy_o), 64'd0);
      chk("rst_done", 64'(sdb_done_o), 64'd0);
      chk("rst_err", 64'(sdb_err_o), 64'd0);

      // Nominal load, then start ignored once done
      reset_dut();
      add(0, M_CLEAN, 1);
      add(1, M_CLEAN, 1);
      start_init(50);
      do_load();
      wait_term(200);
      check_final(1'b1, 1'b0, 2'b00, 1'b1);
      sdb_start_i = 1'b1;
      repeat (3) @(negedge clk);
      sdb_start_i = 1'b0;
      repeat (20) @(negedge clk);
      chk("start_ignored_cmds", 64'(en_count), 64'd2);
      chk("start_ignored_busy", 64'(sdb_busy_o), 64'd0);

      // Single error mid-block, block re-read from its base
      reset_dut();
      add(0, M_ERR, 40);
      add(0, M_CLEAN, 0);
      add(1, M_CLEAN, 0);
      start_init(int'($urandom_range(1, 60)));
      do_load();
      wait_term(200);
      check_final(1'b1, 1'b0, 2'b00, 1'b1);

      // Short block, then overflow, then clean
      reset_dut();
      add(0, M_SHORT, 0);
      add(0, M_OVER, 0);
      add(0, M_CLEAN, 0);
      add(1, M_CLEAN, 0);
      start_init(5);
      do_load();
      wait_term(200);
      check_final(1'b1, 1'b0, 2'b00, 1'b1);

      // All MAX_RETRY retries used on each block; retry count resets per block
      reset_dut();
      for (int b = 0; b < 2; b++) begin
         for (int r = 0; r < 3; r++) add(b, M_ERR, int'($urandom_range(0, 127)));
         add(b, M_CLEAN, 0);
      end
      start_init(3);
      do_load();
      wait_term(200);
      check_final(1'b1, 1'b0, 2'b00, 1'b1);

      // Retry exhaustion on errors
      reset_dut();
      for (int r = 0; r < 4; r++) add(0, M_ERR, int'($urandom_range(0, 127)));
      start_init(2);
      do_load();
      wait_term(200);
      check_final(1'b0, 1'b1, 2'b11, 1'b0);
      chk("exhaust_pulses", 64'(en_count), 64'd4);

      // Exhaustion where every failure is a data timeout
      reset_dut();
      for (int r = 0; r < 4; r++) add(0, M_TIMEOUT, 0);
      start_init(2);
      do_load();
      wait_term(2500);
      check_final(1'b0, 1'b1, 2'b10, 1'b0);

      // Timeouts followed by a final error report code 11
      reset_dut();
      for (int r = 0; r < 3; r++) add(0, M_TIMEOUT, 0);
      add(0, M_ERR, 7);
      start_init(2);
      do_load();
      wait_term(200);
      check_final(1'b0, 1'b1, 2'b11, 1'b0);

      // Init timeout
      reset_dut();
      sdb_start_i = 1'b1;
      @(negedge clk);
      sdb_start_i = 1'b0;
      cyc = 1;
      while (!sdb_err_o && cyc < 3000) begin
         @(negedge clk);
         cyc++;
      end
      chk("init_to_window", 64'(cyc >= 990 && cyc <= 1010), 64'd1);
      check_final(1'b0, 1'b1, 2'b01, 1'b0);
      chk("init_to_no_cmd", 64'(en_count), 64'd0);

      // Async reset in the middle of a block, then a full restart
      reset_dut();
      begin
         logic ok;
         start_init(10);
         wait_enable(ok);
         if (ok) serve(0, M_PARTIAL, 60);
      end
      #2 rst_n = 1'b0;
      #1;
      chk("arst_we", 64'(mem_we_o), 64'd0);
      chk("arst_addr", 64'(mem_addr_o), 64'd0);
      chk("arst_data", 64'(mem_data_o), 64'd0);
      chk("arst_init", 64'(spi_init_o), 64'd0);
      chk("arst_en", 64'(spi_enableoper_o), 64'd0);
      chk("arst_status", 64'(spi_statusreg_o), 64'h00);
      chk("arst_cmd", 64'(spi_cmd_o), 64'h0);
      chk("arst_busy", 64'(sdb_busy_o), 64'd0);
      chk("arst_done", 64'(sdb_done_o), 64'd0);
      chk("arst_err", 64'(sdb_err_o), 64'd0);
      spi_initdone_i = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      clear_all();
      add(0, M_CLEAN, 0);
      add(1, M_CLEAN, 0);
      start_init(8);
      do_load();
      wait_term(200);
      check_final(1'b1, 1'b0, 2'b00, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/sd_boot_sequencer.md
Name: sd_boot_sequencer

Overview:
- Controller sequencing the SPI microSDHC core during boot.
- Initialises the card, then issues single-block reads (CMD17) for NUM_BLOCKS consecutive LBAs, starting at START_LBA.
- Writes each returned 32-bit word into boot memory through a simple write port.
- Reports done/error to the boot FSM; retries failed blocks and enforces timeouts.

Parameters:
- START_LBA, 32'd0, first SDHC block address read.
- NUM_BLOCKS, 8, blocks to load (1..255).
- MEM_AW, 12, boot memory word-address width; must be ≥ log2(NUM_BLOCKS*128).
- TIMEOUT, 20'd100000, max cycles without core activity before abort.
- MAX_RETRY, 3, re-issues allowed per block after a failed read.

Ports:
- sdb_clk_i  in  1  system clock.
- sdb_rst_i  in  1  reset; asynchronous, active-low.
- sdb_start_i  in  1  level or pulse; begins the boot load when in IDLE.
- spi_init_o  out  1  to core spi_init_i; requests card init.
- spi_initdone_i  in  1  from core; card initialised.
- spi_enableoper_o  out  1  to core; one-cycle command-issue strobe.
- spi_statusreg_o  out  8  to core; opcode, 8'h00 idle, 8'h11 read single block.
- spi_cmd_o  out  48  to core spi_data_i; command frame.
- spi_data_i  in  32  from core; read data word.
- spi_flagreg_i  in  3  from core; [0] word valid pulse, [1] block complete pulse, [2] error pulse.
- mem_we_o  out  1  boot memory write enable.
- mem_addr_o  out  MEM_AW  word address.
- mem_data_o  out  32  write data.
- sdb_busy_o  out  1  load in progress.
- sdb_done_o  out  1  sticky; all blocks loaded.
- sdb_err_o  out  1  sticky; load aborted.
- sdb_errcode_o  out  2  01 init timeout, 10 data timeout, 11 retries exhausted.

Behaviour:
- Reset (async, any state): FSM→IDLE. All outputs 0, except spi_statusreg_o = 8'h00 and spi_cmd_o = 48'h0. Counters cleared.
- IDLE: sdb_start_i=1 → INIT.
- INIT: spi_init_o=1, held until spi_initdone_i=1, then → CMD_SETUP. Timeout → ERROR, code 01.
- CMD_SETUP (1 cycle): latch spi_cmd_o = {8'h51, lba[31:0], 8'hFF}, with lba = START_LBA + blk_idx. spi_statusreg_o=8'h11. word_cnt=0. Next → CMD_ISSUE.
- CMD_ISSUE (1 cycle): spi_enableoper_o=1 → DATA.
- DATA:
  - flag[0] with word_cnt<128: mem_we_o=1 that cycle, mem_data_o=spi_data_i, mem_addr_o = blk_idx*128 + word_cnt, word_cnt++. Write happens in the flag cycle's registered output (1-cycle latency).
  - flag[1] with word_cnt==128 → BLK_DONE.
  - Failure cases → RETRY:
    - flag[2];
    - flag[1] with word_cnt≠128;
    - flag[0] with word_cnt==128 (overflow; no write);
    - timeout.
- Simultaneous flags in one cycle: flag[2] beats flag[0]/[1]; no write on an error cycle.
- BLK_DONE: blk_idx++. If blk_idx==NUM_BLOCKS → DONE, else → CMD_SETUP.
- RETRY:
  - retry_cnt<MAX_RETRY: retry_cnt++ → CMD_SETUP, same blk_idx; memory address rewinds to block base, so the block is overwritten.
  - Otherwise → ERROR, code 11, or code 10 if the last failure was a timeout.
  - retry_cnt clears at each BLK_DONE.
- Timeout counter: clears on state change and on any flag bit set. Saturates at TIMEOUT and fires the abort.
- DONE/ERROR: terminal until reset. sdb_busy_o=0, spi_statusreg_o=8'h00. sdb_start_i ignored.
- sdb_busy_o=1 in all states except IDLE/DONE/ERROR. sdb_start_i while busy is ignored.
- spi_init_o is held at 1 from INIT onward; it is not dropped after init.

Decomposition:
- Package sdb_pkg:
  - state enum (IDLE, INIT, CMD_SETUP, CMD_ISSUE, DATA, BLK_DONE, RETRY, DONE, ERROR);
  - constants CMD17=8'h51, OP_READ=8'h11, OP_IDLE=8'h00, WORDS_PER_BLK=128;
  - flag bit indices;
  - error codes.
- One sub-module, sdb_timeout_ctr: clear/enable inputs, expired output; reused for both the INIT and DATA waits.

Test Plan:
- Nominal: NUM_BLOCKS=2, START_LBA=32'h100, initdone after 50 cycles, model returns 128 words of 32'hA000_0000+i per block → spi_cmd_o=48'h51_00000100_FF then 48'h51_00000101_FF; 256 writes at addr 0..255 with matching data; sdb_done_o=1, sdb_err_o=0.
- Single error: flag[2] at word 40 of block 0, clean afterwards → block 0 re-issued with the same LBA; addr restarts at 0; final memory contents correct; done=1.
- Retry exhaustion: MAX_RETRY=3, every read errors → exactly 4 spi_enableoper_o pulses; sdb_err_o=1, sdb_errcode_o=2'b11; busy=0.
- Init timeout: spi_initdone_i held at 0, TIMEOUT=1000 → ERROR with code 01 about 1000 cycles after start; no spi_enableoper_o pulses.
- Short block / overflow: block complete after 127 words → retry; then 129 word pulses → no write for the 129th pulse, retry.
- Async reset asserted in DATA at word 60 → all outputs 0 immediately; a new sdb_start_i restarts from INIT and reads LBA START_LBA.
